// File: rtl/aes_decipher_ctrl.sv
// aes_decipher_ctrl
// Round sequencer for the combinational AES decipher datapath. Holds the
// cipher state between rounds and walks the round keys from Nr down to 0:
// one INIT round, Nr-1 MAIN rounds, one FINAL round, one round per clock.
module aes_decipher_ctrl #(
    parameter int unsigned NR_128 = 10,
    parameter int unsigned NR_256 = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic         ready,
    output logic [1:0]   round_type,
    output logic [3:0]   round_key_idx,
    output logic [127:0] state_out,
    input  logic [127:0] state_in,
    output logic [127:0] result,
    output logic         result_valid
);

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_INIT,
        FSM_MAIN,
        FSM_FINAL
    } fsm_e;

    localparam logic [1:0] RT_INIT  = 2'd0;
    localparam logic [1:0] RT_MAIN  = 2'd1;
    localparam logic [1:0] RT_FINAL = 2'd2;
    localparam logic [1:0] RT_NOP   = 2'd3;

    localparam logic [3:0] NR_128_IDX = 4'(NR_128);
    localparam logic [3:0] NR_256_IDX = 4'(NR_256);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_reg_q, state_reg_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [3:0]   round_ctr_dec;
    logic         keylen_q, keylen_d;
    logic         ready_q, ready_d;
    logic         result_valid_q, result_valid_d;

    // Saturating decrement: the round counter never wraps below zero.
    always_comb begin
        round_ctr_dec = (round_ctr_q == '0) ? '0 : round_ctr_q - 4'd1;
    end

    // Next-state logic: accept a block in IDLE, then step one round per clock.
    always_comb begin
        fsm_d          = fsm_q;
        state_reg_d    = state_reg_q;
        round_ctr_d    = round_ctr_q;
        keylen_d       = keylen_q;
        ready_d        = ready_q;
        result_valid_d = result_valid_q;

        case (fsm_q)
            FSM_IDLE: begin
                if (next && ready_q) begin
                    state_reg_d    = block;
                    keylen_d       = keylen;
                    round_ctr_d    = keylen ? NR_256_IDX : NR_128_IDX;
                    result_valid_d = 1'b0;
                    ready_d        = 1'b0;
                    fsm_d          = FSM_INIT;
                end
            end

            FSM_INIT: begin
                state_reg_d = state_in;
                round_ctr_d = round_ctr_dec;
                fsm_d       = FSM_MAIN;
            end

            FSM_MAIN: begin
                state_reg_d = state_in;
                round_ctr_d = round_ctr_dec;
                if (round_ctr_q <= 4'd1) begin
                    fsm_d = FSM_FINAL;
                end
            end

            FSM_FINAL: begin
                state_reg_d    = state_in;
                ready_d        = 1'b1;
                result_valid_d = 1'b1;
                fsm_d          = FSM_IDLE;
            end

            default: begin
                fsm_d = FSM_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset; reset discards any block in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q          <= FSM_IDLE;
            state_reg_q    <= '0;
            round_ctr_q    <= '0;
            keylen_q       <= 1'b0;
            ready_q        <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            fsm_q          <= fsm_d;
            state_reg_q    <= state_reg_d;
            round_ctr_q    <= round_ctr_d;
            keylen_q       <= keylen_d;
            ready_q        <= ready_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Datapath controls decoded from registered state only.
    // The INIT key index is taken from the latched key length; it always
    // equals round_ctr at that point because the counter was loaded with Nr.
    always_comb begin
        round_type    = RT_NOP;
        round_key_idx = '0;
        case (fsm_q)
            FSM_INIT: begin
                round_type    = RT_INIT;
                round_key_idx = keylen_q ? NR_256_IDX : NR_128_IDX;
            end
            FSM_MAIN: begin
                round_type    = RT_MAIN;
                round_key_idx = round_ctr_q;
            end
            FSM_FINAL: begin
                round_type    = RT_FINAL;
                round_key_idx = '0;
            end
            default: begin
                round_type    = RT_NOP;
                round_key_idx = '0;
            end
        endcase
    end

    assign ready        = ready_q;
    assign result_valid = result_valid_q;
    assign state_out    = state_reg_q;
    assign result       = state_reg_q;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// tb_aes_decipher_ctrl
// Directed bench for the decipher round sequencer. The datapath is either a
// simple XOR-fold model or a behavioural AES inverse round with key schedule.
`timescale 1ns/1ps
module tb_aes_decipher_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [127:0] block;
    logic         ready;
    logic [1:0]   round_type;
    logic [3:0]   round_key_idx;
    logic [127:0] state_out;
    logic [127:0] state_in;
    logic [127:0] result;
    logic         result_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic         use_aes = 1'b0;
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];

    logic [127:0] exp_q [$];
    logic [5:0]   seq_q [$];

    always #5 clk = ~clk;

    aes_decipher_ctrl #(
        .NR_128(10),
        .NR_256(14)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .next         (next),
        .keylen       (keylen),
        .block        (block),
        .ready        (ready),
        .round_type   (round_type),
        .round_key_idx(round_key_idx),
        .state_out    (state_out),
        .state_in     (state_in),
        .result       (result),
        .result_valid (result_valid)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Behavioural inverse round: INIT=AddRoundKey; MAIN=InvShiftRows,
    // InvSubBytes, AddRoundKey, InvMixColumns; FINAL drops InvMixColumns.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [1:0] rt,
                                               input logic [127:0] k);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        if (rt == 2'd3) return s;
        if (rt == 2'd0) return s ^ k;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = isbox[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
            end
        end
        t = t ^ k;
        if (rt == 2'd1) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8];
                a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8];
                a3 = t[103-32*c -: 8];
                t[127-32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                t[119-32*c -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                t[111-32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                t[103-32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
            end
        end
        return t;
    endfunction

    // Key memory contents: standard forward key schedule, round key r in rk[r].
    task automatic expand_key(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Expected plaintext under the XOR-fold datapath model.
    function automatic logic [127:0] xor_model(input logic kl, input logic [127:0] blk);
        logic [127:0] s;
        int nr;
        nr = kl ? 14 : 10;
        s = blk ^ {122'h0, 2'd0, 4'(nr)};
        for (int r = nr - 1; r >= 1; r--) s = s ^ {122'h0, 2'd1, 4'(r)};
        s = s ^ {122'h0, 2'd2, 4'd0};
        return s;
    endfunction

    // Round datapath driven by the controller outputs.
    always_comb begin
        if (use_aes) state_in = aes_round(state_out, round_type, rk[round_key_idx]);
        else         state_in = state_out ^ {120'h0, 2'b00, round_type, round_key_idx};
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive a start request and push the expected round sequence and result.
    task automatic accept(input logic kl, input logic [127:0] blk, input logic [127:0] expv,
                          input logic hold);
        int nr;
        nr = kl ? 14 : 10;
        check("ready_before_accept", 128'(ready), 128'd1);
        exp_q.push_back(expv);
        seq_q.push_back({2'd0, 4'(nr)});
        for (int r = nr - 1; r >= 1; r--) seq_q.push_back({2'd1, 4'(r)});
        seq_q.push_back({2'd2, 4'd0});
        next   = 1'b1;
        keylen = kl;
        block  = blk;
        @(posedge clk);
        #1;
        if (!hold) next = 1'b0;
    endtask

    // Follow one run from the accept edge until ready rises (bounded).
    task automatic follow(input int nr, input logic [127:0] blk, input string tag);
        int         lat;
        logic       done;
        logic [5:0] e;
        lat  = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check({tag, "_valid_drop"}, 128'(result_valid), 128'd0);
                check({tag, "_loaded"}, result, blk);
            end
            if (ready) begin
                done = 1'b1;
            end else begin
                if (seq_q.size() == 0) begin
                    check({tag, "_extra_round"}, 128'(round_type), 128'd3);
                end else begin
                    e = seq_q.pop_front();
                    check({tag, "_round_type"}, 128'(round_type), 128'(e[5:4]));
                    check({tag, "_key_idx"}, 128'(round_key_idx), 128'(e[3:0]));
                end
                check({tag, "_state_out"}, state_out, result);
                @(posedge clk);
                lat++;
            end
        end
        check({tag, "_done"}, 128'(done), 128'd1);
        check({tag, "_latency"}, 128'(lat), 128'(nr + 1));
        check({tag, "_seq_left"}, 128'(seq_q.size()), 128'd0);
        check({tag, "_result_valid"}, 128'(result_valid), 128'd1);
        if (exp_q.size() == 0) check({tag, "_no_expected"}, 128'd1, 128'd0);
        else                   check({tag, "_result"}, result, exp_q.pop_front());
    endtask

    initial begin
        logic [7:0]   p, q, x;
        logic [127:0] ba, bb, bc;
        logic         kl;

        reset  = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = '0;

        // S-box by walking the multiplicative group with generator 3.
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ xtime(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
        for (int i = 0; i < 16; i++) rk[i] = '0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 128'(ready), 128'd1);
        check("rst_result_valid", 128'(result_valid), 128'd0);
        check("rst_round_type", 128'(round_type), 128'd3);
        check("rst_key_idx", 128'(round_key_idx), 128'd0);
        check("rst_result", result, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // AES-128 sequencing, block of zeros
        accept(1'b0, 128'd0, xor_model(1'b0, 128'd0), 1'b0);
        follow(10, 128'd0, "seq128");

        // AES-256 sequencing
        ba = {$urandom, $urandom, $urandom, $urandom};
        accept(1'b1, ba, xor_model(1'b1, ba), 1'b0);
        follow(14, ba, "seq256");

        // Busy handling: next held high, block and keylen changed mid-run
        ba = {$urandom, $urandom, $urandom, $urandom};
        bb = ~ba;
        accept(1'b0, ba, xor_model(1'b0, ba), 1'b1);
        block  = bb;
        keylen = 1'b1;
        follow(10, ba, "busyA");
        accept(1'b1, bb, xor_model(1'b1, bb), 1'b0);
        follow(14, bb, "busyB");

        // Asynchronous reset in the middle of MAIN (5th round)
        ba = {$urandom, $urandom, $urandom, $urandom};
        accept(1'b0, ba, xor_model(1'b0, ba), 1'b0);
        repeat (5) @(negedge clk);
        check("pre_rst_round_type", 128'(round_type), 128'd1);
        check("pre_rst_key_idx", 128'(round_key_idx), 128'd6);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_ready", 128'(ready), 128'd1);
        check("mid_rst_result_valid", 128'(result_valid), 128'd0);
        check("mid_rst_round_type", 128'(round_type), 128'd3);
        check("mid_rst_key_idx", 128'(round_key_idx), 128'd0);
        check("mid_rst_result", result, 128'd0);
        #1 reset = 1'b0;
        exp_q.delete();
        seq_q.delete();
        ba = {$urandom, $urandom, $urandom, $urandom};
        accept(1'b0, ba, xor_model(1'b0, ba), 1'b0);
        follow(10, ba, "post_rst");

        // Back-to-back: each new block on the first edge after ready rises
        for (int n = 0; n < 3; n++) begin
            kl = (n == 1);
            bc = {$urandom, $urandom, $urandom, $urandom};
            accept(kl, bc, xor_model(kl, bc), 1'b0);
            follow(kl ? 14 : 10, bc, $sformatf("b2b%0d", n));
        end

        // End-to-end with behavioural round datapath and key memory
        use_aes = 1'b1;
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
        accept(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               128'h00112233445566778899aabbccddeeff, 1'b0);
        follow(10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "e2e128");

        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);
        accept(1'b1, 128'h8ea2b7ca516745bfeafc49904b496089,
               128'h00112233445566778899aabbccddeeff, 1'b0);
        follow(14, 128'h8ea2b7ca516745bfeafc49904b496089, "e2e256");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_decipher_ctrl.md
Name: aes_decipher_ctrl

Overview:
- Sequencing controller for the combinational AES decipher round datapath.
- Accepts one 128-bit ciphertext block and holds the cipher state in a register.
- Drives the round datapath one round per clock: round type, state, round key index.
- Sequence: INIT round with key Nr, MAIN rounds with keys Nr-1..1, FINAL round with key 0.
- Sits between the core top-level control and the round datapath / key memory. It never touches key data itself; the key memory resolves round_key_idx to round_key.

Parameters:
- NR_128, 10, number of rounds for 128-bit keys.
- NR_256, 14, number of rounds for 256-bit keys.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- next  input  1  start request; sampled only while ready=1.
- keylen  input  1  key size, 0=128-bit, 1=256-bit; sampled with next.
- block  input  128  ciphertext block, byte 0 in [127:120]; sampled with next.
- ready  output  1  1 = idle and able to accept next.
- round_type  output  2  to datapath: 0=INIT, 1=MAIN, 2=FINAL, 3=idle/no-op.
- round_key_idx  output  4  to key memory: round key index for the current round.
- state_out  output  128  current state register, to datapath input.
- state_in  input  128  datapath result for the current round.
- result  output  128  plaintext; equals state register contents.
- result_valid  output  1  1 = result holds a completed block.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FSM=IDLE, state_reg=0, round_ctr=0, keylen_reg=0.
  - ready=1, result_valid=0, round_type=3, round_key_idx=0.
  - Any in-flight block is discarded.
- FSM states: IDLE, INIT, MAIN, FINAL. Encoding is free; no other reachable states.
- All outputs are registered or decoded directly from registered state only; no combinational path from input to output.
- IDLE:
  - Drives round_type=3, round_key_idx=0.
  - On edge with next=1: state_reg<=block, keylen_reg<=keylen, round_ctr<=Nr, result_valid<=0, ready<=0, go INIT.
  - Nr = NR_256 if keylen=1, else NR_128.
- INIT:
  - Drives round_type=0, round_key_idx=round_ctr (=Nr).
  - Edge: state_reg<=state_in, round_ctr<=round_ctr-1, go MAIN.
- MAIN:
  - Drives round_type=1, round_key_idx=round_ctr.
  - Edge: state_reg<=state_in, round_ctr<=round_ctr-1.
  - If round_ctr==1 before the decrement, go FINAL (round_ctr becomes 0).
- FINAL:
  - Drives round_type=2, round_key_idx=0.
  - Edge: state_reg<=state_in, ready<=1, result_valid<=1, go IDLE.
- Latency: Nr+1 clocks from the edge that samples next to the edge that sets ready/result_valid (11 for AES-128, 15 for AES-256). MAIN executes Nr-1 times.
- round_ctr is 4 bits and never wraps. It decrements only in INIT and MAIN and never goes below 0.
- next while ready=0 is ignored; keylen and block changes during a run are ignored.
- next on the same edge that FINAL completes is ignored: ready is still 0 on that edge. The earliest new accept is the following edge.
- result_valid:
  - Stays 1 and result stays stable until the next accepted start.
  - On the accept edge, result_valid clears and result takes the new block value (state_reg<=block).
- state_out == result == state_reg at all times.

Test Plan:
- Reset check: assert reset mid-MAIN (AES-128, 5th round) -> immediately ready=1, result_valid=0, round_type=3, result=0, with no clock edge needed. A new next after deassertion runs a full 11-cycle sequence.
- Sequencing, AES-128, datapath model state_in = state_out ^ {120'h0, 2'b0, round_type, round_key_idx}:
  - keylen=0, block=0, pulse next.
  - round_key_idx sequence must be 10,9,...,1,0 with round_type 0, then 1 x9, then 2.
  - ready=1 exactly 11 cycles after accept; result matches the model's XOR fold.
- Sequencing, AES-256, same model: keylen=1 -> idx 14..0, MAIN x13, ready after 15 cycles.
- Busy handling, AES-128:
  - Hold next=1 continuously with block=A, then B -> A is accepted; B is ignored while busy.
  - Second accept happens one edge after ready rises, and result_valid drops on that edge.
  - keylen toggled mid-run has no effect on round count.
- End-to-end with round datapath and key memory:
  - Setup: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: result=00112233445566778899aabbccddeeff, result_valid=1.
  - Repeat with the AES-256 key 00..1f and ciphertext 8ea2b7ca516745bfeafc49904b496089 -> same plaintext.
- Back-to-back: three blocks issued on each first-possible edge -> each completes in exactly Nr+1 cycles with no gap cycles beyond the single ready cycle.
